// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the RAM port arbiter
package ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - one requester port of the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-input round-robin arbiter with one priority flop
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // 0 favours A, 1 favours B; only contention moves it
    logic prio_b_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                if (prio_b_q) gnt_o[REQ_B] = 1'b1;
                else          gnt_o[REQ_A] = 1'b1;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else if (en_i && (req_i == 2'b11)) begin
            prio_b_q <= ~prio_b_q;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - clears a single-port RAM, then arbitrates ports A and B onto it
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     port_a,
    ram_port_arbiter_if.slave     port_b,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] din_hold_q;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
    logic                  rvalid_a_q, rvalid_b_q;
    logic                  init_done_q;
    logic [1:0]            gnt;
    logic                  rd_a, rd_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({port_b.req, port_a.req}),
        .en_i  (state_q == RUN),
        .gnt_o (gnt)
    );

    assign rd_a = gnt[REQ_A] & ~port_a.we;
    assign rd_b = gnt[REQ_B] & ~port_b.we;

    // Idle cycles keep the bus parked on the last address/data
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_hold_q;
        ram_din  = din_hold_q;
        if (state_q == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = cnt_q;
            ram_din  = '0;
        end else if (gnt[REQ_A]) begin
            ram_we   = port_a.we;
            ram_addr = port_a.addr;
            ram_din  = port_a.wdata;
        end else if (gnt[REQ_B]) begin
            ram_we   = port_b.we;
            ram_addr = port_b.addr;
            ram_din  = port_b.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            addr_hold_q <= ram_addr;
            din_hold_q  <= ram_din;
            rvalid_a_q  <= rd_a;
            rvalid_b_q  <= rd_b;
            if (rd_a) rdata_a_q <= ram_dout;
            if (rd_b) rdata_b_q <= ram_dout;
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign port_a.gnt    = gnt[REQ_A];
    assign port_b.gnt    = gnt[REQ_B];
    assign port_a.rdata  = rdata_a_q;
    assign port_b.rdata  = rdata_b_q;
    assign port_a.rvalid = rvalid_a_q;
    assign port_b.rvalid = rvalid_b_q;
    assign init_done     = init_done_q;

endmodule
